stack_sequencer: RTL and testbench
==================================

Name: stack_sequencer

Overview:
- Sequences the data-memory accesses of a two-byte stack frame for the MiniRISC CPU.
- Serves three operations: JSR (push), RTS/RTI (pop) and interrupt entry (push).
- Sits between controller_fsm (stack_op_ongoing, push_or_pop, stack_op_end) and the data-bus address/write-data muxes.
- Owns the stack pointer (SP), the depth counter and the overflow/underflow flags.

Parameters:
- SP_INIT, 8'h00: SP value after reset/initialize. The stack is empty; the first push writes 8'hFF.
- STACK_DEPTH, 32: capacity in bytes (even, 2..254). Used for the ovf/unf checks.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- initialize  in  1  synchronous re-init from controller_fsm
- stack_req  in  1  = stack_op_ongoing; held high for the whole operation
- push_or_pop  in  1  1=PUSH, 0=POP; sampled in phase 0 only
- bus_grant  in  1  data-bus grant for the current byte
- push_pc  in  8  return address to push
- push_flags  in  8  {IF,IE,2'b00,V,N,C,Z} to push
- mem_din  in  8  read data; valid in the grant cycle
- stack_addr  out  8  data-memory address for the current byte
- stack_wdata  out  8  write data for the current byte
- stack_op_end  out  1  combinational; high in the grant cycle of the final byte
- pop_pc  out  8  registered popped PC
- pop_flags  out  8  registered popped flags
- sp  out  8  current committed SP
- stack_ovf  out  1  sticky overflow flag
- stack_unf  out  1  sticky underflow flag
- dbg_is_brk  in  1  CPU is in break state
- dbg_sp_wr  in  1  debug SP write enable; effective only when dbg_is_brk=1
- dbg_sp_din  in  8  debug SP value

Behaviour:
- Reset (rst, async):
  - sp=SP_INIT, depth=0, phase=PH0, dir_q=0.
  - pop_pc=0, pop_flags=0, stack_ovf=0, stack_unf=0.
- initialize=1 at a clock edge: same values as reset, synchronously; overrides all other updates.
- States:
  - PH0: idle, or first byte.
  - PH1: second byte.
  - DONE: waiting for stack_req to drop.
- Direction:
  - In PH0, dir = push_or_pop (live).
  - On the PH0 grant edge, dir is latched into dir_q.
  - PH1 uses dir_q, so push_or_pop changes during the operation are ignored.
- Addresses and data, all 8-bit mod 256:
  - PUSH byte0: addr=sp-1, wdata=push_pc.
  - PUSH byte1: addr=sp-2, wdata=push_flags.
  - POP byte0: addr=sp, read into pop_flags.
  - POP byte1: addr=sp+1, read into pop_pc.
  - stack_wdata=0 during POP, and whenever stack_req=0.
  - stack_addr=sp when stack_req=0.
- Transitions:
  - PH0 & stack_req & bus_grant -> PH1.
  - PH1 & stack_req & bus_grant -> DONE.
  - DONE & !stack_req -> PH0.
  - Without a grant, the state holds; byte addr/data stay stable across wait cycles.
- stack_op_end = (phase==PH1) & stack_req & bus_grant. It is never high in PH0 or DONE.
  - Minimum latency is 2 cycles from stack_req rising to stack_op_end.
- Read capture:
  - POP PH0 grant edge: pop_flags <= mem_din.
  - POP PH1 grant edge: pop_pc <= mem_din. Both are valid from the cycle after stack_op_end.
- Commit (final grant edge only):
  - PUSH: sp<=sp-2, depth<=depth+2.
  - POP: sp<=sp+2, depth<=depth-2.
- Abort: stack_req falls in PH1 -> back to PH0; sp and depth unchanged. pop_flags may already be updated.
- Overflow/underflow:
  - On a PUSH commit with depth+2 > STACK_DEPTH: stack_ovf<=1.
  - On a POP commit with depth<2: stack_unf<=1, and depth saturates at 0.
  - The operation still completes and sp wraps mod 256.
- Flag clearing: cleared only by rst/initialize, or by a dbg_sp_wr write.
- Debug write:
  - dbg_is_brk & dbg_sp_wr & phase==PH0 -> sp<=dbg_sp_din, depth<=0, ovf=unf=0.
  - Ignored when dbg_is_brk=0 or phase!=PH0.
- Simultaneous events: initialize > dbg write > commit.

Test Plan:
- Push (sp=00, pc=3C, flags=C5, grant always 1):
  - Cycle 1: addr=FF, wdata=3C.
  - Cycle 2: addr=FE, wdata=C5, stack_op_end=1.
  - Then sp=FE, depth=2.
- Pop after the push (sp=FE, mem[FE]=C5, mem[FF]=3C):
  - Byte addresses FE then FF.
  - pop_flags=C5, pop_pc=3C, sp=00, end pulse 1 cycle.
- Grant stalls: bus_grant low 3 cycles in PH0 and 2 cycles in PH1.
  - addr/wdata held stable throughout.
  - stack_op_end only on the final grant; total 7 cycles.
- Direction flip: push_or_pop toggles to POP in PH1 of a push.
  - Second byte is still a write at sp-2; sp decrements by 2.
- Overflow and underflow:
  - STACK_DEPTH=4, 3 pushes -> stack_ovf=1 after the 3rd; sp=FA (wrap check).
  - From reset, a pop -> stack_unf=1, depth=0, sp=02.
- Abort/reset:
  - stack_req drops in PH1 -> sp unchanged, phase=PH0.
  - Async rst mid-PH1 -> immediate sp=00, outputs 0.
  - dbg_sp_wr with dbg_is_brk=1, din=80 -> sp=80, flags cleared.

Source files
------------

// File: rtl/stack_sequencer.sv
// Two-byte stack frame sequencer for MiniRISC: drives the data-memory address/data
// for JSR/IRQ pushes and RTS/RTI pops, and owns SP, depth and the ovf/unf flags.
module stack_sequencer #(
    parameter logic [7:0] SP_INIT     = 8'h00,
    parameter int         STACK_DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       initialize,
    input  logic       stack_req,
    input  logic       push_or_pop,
    input  logic       bus_grant,
    input  logic [7:0] push_pc,
    input  logic [7:0] push_flags,
    input  logic [7:0] mem_din,
    output logic [7:0] stack_addr,
    output logic [7:0] stack_wdata,
    output logic       stack_op_end,
    output logic [7:0] pop_pc,
    output logic [7:0] pop_flags,
    output logic [7:0] sp,
    output logic       stack_ovf,
    output logic       stack_unf,
    input  logic       dbg_is_brk,
    input  logic       dbg_sp_wr,
    input  logic [7:0] dbg_sp_din
);

    localparam logic [1:0] PH0  = 2'd0;
    localparam logic [1:0] PH1  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] r_phase;
    logic       r_dir_q;
    logic [7:0] r_sp;
    logic [7:0] r_depth;
    logic [7:0] r_pop_pc;
    logic [7:0] r_pop_flags;
    logic       r_ovf;
    logic       r_unf;

    logic       w_dir;
    logic       w_grant;
    logic       w_dbg_wr;
    logic [8:0] w_depth_inc;

    // PH1 keeps the direction latched at the first grant, so a late flip is ignored
    assign w_dir       = (r_phase == PH0) ? push_or_pop : r_dir_q;
    assign w_grant     = stack_req & bus_grant;
    assign w_dbg_wr    = dbg_is_brk & dbg_sp_wr & (r_phase == PH0);
    assign w_depth_inc = {1'b0, r_depth} + 9'd2;

    assign stack_op_end = (r_phase == PH1) & w_grant;
    assign sp           = r_sp;
    assign pop_pc       = r_pop_pc;
    assign pop_flags    = r_pop_flags;
    assign stack_ovf    = r_ovf;
    assign stack_unf    = r_unf;

    always_comb begin
        stack_addr  = r_sp;
        stack_wdata = 8'h00;
        if (stack_req) begin
            case (r_phase)
                PH0: begin
                    stack_addr  = w_dir ? (r_sp - 8'd1) : r_sp;
                    stack_wdata = w_dir ? push_pc : 8'h00;
                end
                PH1: begin
                    stack_addr  = w_dir ? (r_sp - 8'd2) : (r_sp + 8'd1);
                    stack_wdata = w_dir ? push_flags : 8'h00;
                end
                default: begin
                    stack_addr  = r_sp;
                    stack_wdata = 8'h00;
                end
            endcase
        end
    end

    // Priority: initialize, then debug SP write, then the commit of a finished frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase     <= PH0;
            r_dir_q     <= 1'b0;
            r_sp        <= SP_INIT;
            r_depth     <= 8'd0;
            r_pop_pc    <= 8'h00;
            r_pop_flags <= 8'h00;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else if (initialize) begin
            r_phase     <= PH0;
            r_dir_q     <= 1'b0;
            r_sp        <= SP_INIT;
            r_depth     <= 8'd0;
            r_pop_pc    <= 8'h00;
            r_pop_flags <= 8'h00;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            case (r_phase)
                PH0: begin
                    if (w_grant) begin
                        r_phase <= PH1;
                        r_dir_q <= push_or_pop;
                        if (!push_or_pop)
                            r_pop_flags <= mem_din;
                    end
                end
                PH1: begin
                    if (!stack_req) begin
                        r_phase <= PH0;
                    end else if (bus_grant) begin
                        r_phase <= DONE;
                        if (!r_dir_q)
                            r_pop_pc <= mem_din;
                    end
                end
                default: begin
                    if (!stack_req)
                        r_phase <= PH0;
                end
            endcase

            if (w_dbg_wr) begin
                r_sp    <= dbg_sp_din;
                r_depth <= 8'd0;
                r_ovf   <= 1'b0;
                r_unf   <= 1'b0;
            end else if (stack_op_end) begin
                if (r_dir_q) begin
                    r_sp    <= r_sp - 8'd2;
                    r_depth <= w_depth_inc[7:0];
                    if (w_depth_inc > 9'(STACK_DEPTH))
                        r_ovf <= 1'b1;
                end else begin
                    r_sp <= r_sp + 8'd2;
                    if (r_depth < 8'd2) begin
                        r_depth <= 8'd0;
                        r_unf   <= 1'b1;
                    end else begin
                        r_depth <= r_depth - 8'd2;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: push/pop frames, grant stalls, direction flip,
// overflow/underflow, abort, async reset, debug SP write and initialize.
module tb_stack_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       initialize;
    logic       stack_req;
    logic       push_or_pop;
    logic       bus_grant;
    logic [7:0] push_pc;
    logic [7:0] push_flags;
    logic [7:0] mem_din;
    logic [7:0] stack_addr;
    logic [7:0] stack_wdata;
    logic       stack_op_end;
    logic [7:0] pop_pc;
    logic [7:0] pop_flags;
    logic [7:0] sp;
    logic       stack_ovf;
    logic       stack_unf;
    logic       dbg_is_brk;
    logic       dbg_sp_wr;
    logic [7:0] dbg_sp_din;

    logic [7:0] mem [256];
    int         passCount = 0;
    int         checkCount = 0;

    // Small depth so the overflow boundary is reachable with three pushes
    stack_sequencer #(.SP_INIT(8'h00), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .initialize(initialize),
        .stack_req(stack_req), .push_or_pop(push_or_pop), .bus_grant(bus_grant),
        .push_pc(push_pc), .push_flags(push_flags), .mem_din(mem_din),
        .stack_addr(stack_addr), .stack_wdata(stack_wdata), .stack_op_end(stack_op_end),
        .pop_pc(pop_pc), .pop_flags(pop_flags), .sp(sp),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf),
        .dbg_is_brk(dbg_is_brk), .dbg_sp_wr(dbg_sp_wr), .dbg_sp_din(dbg_sp_din)
    );

    always #5 clk = ~clk;

    assign mem_din = mem[stack_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        stack_req = 1'b0; push_or_pop = 1'b0; bus_grant = 1'b0;
        initialize = 1'b0; dbg_is_brk = 1'b0; dbg_sp_wr = 1'b0; dbg_sp_din = 8'h00;
        #3;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    // Unchecked push used to set up state; mirrors the frame into the memory model
    task automatic do_push(input logic [7:0] pc, input logic [7:0] fl, input logic [7:0] spBefore);
        push_pc = pc; push_flags = fl;
        stack_req = 1'b1; push_or_pop = 1'b1; bus_grant = 1'b1;
        tick(); tick();
        stack_req = 1'b0; bus_grant = 1'b0;
        tick();
        mem[spBefore - 8'd1] = pc;
        mem[spBefore - 8'd2] = fl;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        stack_req = 1'b0; push_or_pop = 1'b0; bus_grant = 1'b0;
        initialize = 1'b0; dbg_is_brk = 1'b0; dbg_sp_wr = 1'b0; dbg_sp_din = 8'h00;
        push_pc = 8'h00; push_flags = 8'h00;
        #12;
        checkCount++; if (sp !== 8'h00) $display("[TB] FAIL reset_sp got=%h exp=00", sp); else passCount++;
        checkCount++; if ({stack_ovf, stack_unf, stack_op_end} !== 3'b000)
            $display("[TB] FAIL reset_flags got=%b exp=000", {stack_ovf, stack_unf, stack_op_end}); else passCount++;
        checkCount++; if ({pop_pc, pop_flags} !== 16'h0000)
            $display("[TB] FAIL reset_pop got=%h exp=0000", {pop_pc, pop_flags}); else passCount++;
        checkCount++; if ({stack_addr, stack_wdata} !== 16'h0000)
            $display("[TB] FAIL reset_bus got=%h exp=0000", {stack_addr, stack_wdata}); else passCount++;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_push;
        push_pc = 8'h3C; push_flags = 8'hC5;
        stack_req = 1'b1; push_or_pop = 1'b1; bus_grant = 1'b1;
        #1;
        checkCount++; if ({stack_addr, stack_wdata, stack_op_end} !== {8'hFF, 8'h3C, 1'b0})
            $display("[TB] FAIL push_byte0 got=%h/%h/%b exp=FF/3C/0", stack_addr, stack_wdata, stack_op_end); else passCount++;
        tick();
        checkCount++; if ({stack_addr, stack_wdata, stack_op_end} !== {8'hFE, 8'hC5, 1'b1})
            $display("[TB] FAIL push_byte1 got=%h/%h/%b exp=FE/C5/1", stack_addr, stack_wdata, stack_op_end); else passCount++;
        tick();
        checkCount++; if ({sp, stack_op_end} !== {8'hFE, 1'b0})
            $display("[TB] FAIL push_commit got=%h/%b exp=FE/0", sp, stack_op_end); else passCount++;
        stack_req = 1'b0; bus_grant = 1'b0;
        tick();
        checkCount++; if ({stack_addr, stack_wdata} !== {8'hFE, 8'h00})
            $display("[TB] FAIL idle_bus got=%h/%h exp=FE/00", stack_addr, stack_wdata); else passCount++;
        mem[8'hFF] = 8'h3C; mem[8'hFE] = 8'hC5;
    endtask

    task automatic test_pop;
        stack_req = 1'b1; push_or_pop = 1'b0; bus_grant = 1'b1;
        #1;
        checkCount++; if ({stack_addr, stack_wdata, stack_op_end} !== {8'hFE, 8'h00, 1'b0})
            $display("[TB] FAIL pop_byte0 got=%h/%h/%b exp=FE/00/0", stack_addr, stack_wdata, stack_op_end); else passCount++;
        tick();
        checkCount++; if ({stack_addr, stack_wdata, stack_op_end} !== {8'hFF, 8'h00, 1'b1})
            $display("[TB] FAIL pop_byte1 got=%h/%h/%b exp=FF/00/1", stack_addr, stack_wdata, stack_op_end); else passCount++;
        tick();
        checkCount++; if ({pop_flags, pop_pc, sp, stack_op_end} !== {8'hC5, 8'h3C, 8'h00, 1'b0})
            $display("[TB] FAIL pop_result got=%h/%h/%h/%b exp=C5/3C/00/0", pop_flags, pop_pc, sp, stack_op_end); else passCount++;
        stack_req = 1'b0; bus_grant = 1'b0;
        tick();
    endtask

    task automatic test_grant_stall;
        logic [6:0]  grants;
        logic [55:0] addrs;
        logic [55:0] datas;
        logic [6:0]  ends;
        logic [7:0]  ea, ed;
        grants = 7'b0001001;
        addrs  = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE};
        datas  = {8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'h5B, 8'h5B, 8'h5B};
        ends   = 7'b0000001;
        push_pc = 8'hA1; push_flags = 8'h5B;
        stack_req = 1'b1; push_or_pop = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            bus_grant = grants[i];
            ea = addrs[i*8 +: 8];
            ed = datas[i*8 +: 8];
            #1;
            checkCount++; if ({stack_addr, stack_wdata, stack_op_end} !== {ea, ed, ends[i]})
                $display("[TB] FAIL stall_cyc%0d got=%h/%h/%b exp=%h/%h/%b", 6 - i,
                         stack_addr, stack_wdata, stack_op_end, ea, ed, ends[i]); else passCount++;
            tick();
        end
        stack_req = 1'b0; bus_grant = 1'b0;
        tick();
        checkCount++; if (sp !== 8'hFE) $display("[TB] FAIL stall_sp got=%h exp=FE", sp); else passCount++;
    endtask

    task automatic test_dir_flip;
        push_pc = 8'h77; push_flags = 8'h88;
        stack_req = 1'b1; push_or_pop = 1'b1; bus_grant = 1'b1;
        tick();
        push_or_pop = 1'b0;
        #1;
        checkCount++; if ({stack_addr, stack_wdata, stack_op_end} !== {8'hFE, 8'h88, 1'b1})
            $display("[TB] FAIL flip_byte1 got=%h/%h/%b exp=FE/88/1", stack_addr, stack_wdata, stack_op_end); else passCount++;
        tick();
        stack_req = 1'b0; bus_grant = 1'b0;
        tick();
        checkCount++; if (sp !== 8'hFE) $display("[TB] FAIL flip_sp got=%h exp=FE", sp); else passCount++;
    endtask

    task automatic test_overflow;
        do_push(8'h10, 8'h01, 8'h00);
        do_push(8'h20, 8'h02, 8'hFE);
        checkCount++; if (stack_ovf !== 1'b0) $display("[TB] FAIL ovf_at_limit got=%b exp=0", stack_ovf); else passCount++;
        do_push(8'h30, 8'h03, 8'hFC);
        checkCount++; if ({stack_ovf, sp} !== {1'b1, 8'hFA})
            $display("[TB] FAIL ovf_set got=%b/%h exp=1/FA", stack_ovf, sp); else passCount++;
    endtask

    task automatic test_underflow;
        mem[8'h00] = 8'h11; mem[8'h01] = 8'h22;
        stack_req = 1'b1; push_or_pop = 1'b0; bus_grant = 1'b1;
        tick(); tick();
        stack_req = 1'b0; bus_grant = 1'b0;
        tick();
        checkCount++; if ({stack_unf, stack_ovf, sp} !== {1'b1, 1'b0, 8'h02})
            $display("[TB] FAIL unf_set got=%b/%b/%h exp=1/0/02", stack_unf, stack_ovf, sp); else passCount++;
        checkCount++; if ({pop_flags, pop_pc} !== {8'h11, 8'h22})
            $display("[TB] FAIL unf_data got=%h/%h exp=11/22", pop_flags, pop_pc); else passCount++;
        // Depth saturated at 0: one push back to depth 2 must not overflow
        do_push(8'h44, 8'h55, 8'h02);
        checkCount++; if ({stack_ovf, stack_unf, sp} !== {1'b0, 1'b1, 8'h00})
            $display("[TB] FAIL unf_depth got=%b/%b/%h exp=0/1/00", stack_ovf, stack_unf, sp); else passCount++;
    endtask

    task automatic test_abort;
        push_pc = 8'h99; push_flags = 8'hAA;
        stack_req = 1'b1; push_or_pop = 1'b1; bus_grant = 1'b1;
        tick();
        stack_req = 1'b0; bus_grant = 1'b0;
        tick();
        checkCount++; if ({sp, stack_addr, stack_op_end} !== {8'h00, 8'h00, 1'b0})
            $display("[TB] FAIL abort_sp got=%h/%h/%b exp=00/00/0", sp, stack_addr, stack_op_end); else passCount++;
        stack_req = 1'b1; bus_grant = 1'b1;
        #1;
        checkCount++; if ({stack_addr, stack_wdata, stack_op_end} !== {8'hFF, 8'h99, 1'b0})
            $display("[TB] FAIL abort_restart got=%h/%h/%b exp=FF/99/0", stack_addr, stack_wdata, stack_op_end); else passCount++;
        tick(); tick();
        stack_req = 1'b0; bus_grant = 1'b0;
        tick();
        checkCount++; if (sp !== 8'hFE) $display("[TB] FAIL abort_then_push got=%h exp=FE", sp); else passCount++;
    endtask

    task automatic test_async_reset;
        do_push(8'h3C, 8'hC5, 8'h00);
        stack_req = 1'b1; push_or_pop = 1'b0; bus_grant = 1'b1;
        tick();
        checkCount++; if (pop_flags !== 8'hC5) $display("[TB] FAIL arst_pre got=%h exp=C5", pop_flags); else passCount++;
        #2;
        rst = 1'b1;
        #1;
        checkCount++; if ({sp, pop_flags, pop_pc, stack_op_end, stack_wdata} !== {8'h00, 8'h00, 8'h00, 1'b0, 8'h00})
            $display("[TB] FAIL arst_now got=%h/%h/%h/%b/%h exp=00/00/00/0/00",
                     sp, pop_flags, pop_pc, stack_op_end, stack_wdata); else passCount++;
        stack_req = 1'b0; bus_grant = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_debug_and_init;
        stack_req = 1'b1; push_or_pop = 1'b0; bus_grant = 1'b1;
        tick(); tick();
        stack_req = 1'b0; bus_grant = 1'b0;
        tick();
        dbg_is_brk = 1'b0; dbg_sp_wr = 1'b1; dbg_sp_din = 8'h40;
        tick();
        checkCount++; if ({sp, stack_unf} !== {8'h02, 1'b1})
            $display("[TB] FAIL dbg_ignored got=%h/%b exp=02/1", sp, stack_unf); else passCount++;
        dbg_is_brk = 1'b1; dbg_sp_din = 8'h80;
        tick();
        dbg_sp_wr = 1'b0; dbg_is_brk = 1'b0;
        checkCount++; if ({sp, stack_unf, stack_ovf} !== {8'h80, 1'b0, 1'b0})
            $display("[TB] FAIL dbg_write got=%h/%b/%b exp=80/0/0", sp, stack_unf, stack_ovf); else passCount++;
        initialize = 1'b1;
        tick();
        initialize = 1'b0;
        checkCount++; if ({sp, stack_unf, stack_ovf, pop_flags} !== {8'h00, 1'b0, 1'b0, 8'h00})
            $display("[TB] FAIL init got=%h/%b/%b/%h exp=00/0/0/00", sp, stack_unf, stack_ovf, pop_flags); else passCount++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_push();
        test_pop();
        test_grant_stall();
        do_reset();
        test_dir_flip();
        do_reset();
        test_overflow();
        do_reset();
        test_underflow();
        do_reset();
        test_abort();
        do_reset();
        test_async_reset();
        do_reset();
        test_debug_and_init();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
